// File: rtl/alu_sched_pkg.sv
// Op codes and FSM state type shared by the alu_sched scheduler files.
package alu_sched_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request, shared-ALU and response signals of alu_sched, bundled with scheduler-side
// (slave) and client/environment-side (master) modports.
interface alu_sched_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*3-1:0]     req_op;

    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_control;
    logic [WIDTH-1:0]      alu_result;
    logic                  alu_zero;

    logic [NREQ-1:0]       rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_zero,
        output req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_zero,
        input  req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap, ptr moves past the winner
// only when en is set and a grant is issued.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id
);
    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_idx;
    logic            w_hit;

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        gnt_id = '0;
        gnt    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
            if (!w_hit && req[w_idx]) begin
                w_hit  = 1'b1;
                gnt_id = w_idx;
            end
        end
        if (en && w_hit) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (en && w_hit) begin
            r_ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU among NREQ requesters.
// Define ALU_SCHED_MUL_EN to run op 011 as a WIDTH-cycle shift-add multiply on the shared ALU.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_sched_if.slave bus
);
    localparam int ID_W = $clog2(NREQ);

    state_t           r_state;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_ctrl;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;

    logic             w_accept;
    logic             w_xfer;
    logic [NREQ-1:0]  w_gnt;
    logic [ID_W-1:0]  w_gnt_id;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [2:0]       w_sel_op;

`ifdef ALU_SCHED_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    // mcand/mplier run one step ahead because alu_a/alu_b are registered; r_alu_a is the accumulator.
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0] r_mcnt;
`endif

    assign w_accept = (r_state == IDLE) || (r_state == RESP);
    assign w_xfer   = |w_gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (bus.req_valid),
        .en     (w_accept),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a  = bus.req_a[i*WIDTH +: WIDTH];
                w_sel_b  = bus.req_b[i*WIDTH +: WIDTH];
                w_sel_op = bus.req_op[i*3 +: 3];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_id         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_valid  <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
`ifdef ALU_SCHED_MUL_EN
            r_mcand      <= '0;
            r_mplier     <= '0;
            r_mcnt       <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_xfer) begin
                        r_id       <= w_gnt_id;
                        r_alu_a    <= w_sel_a;
                        r_alu_b    <= w_sel_b;
                        r_alu_ctrl <= w_sel_op;
                        r_state    <= EXEC;
`ifdef ALU_SCHED_MUL_EN
                        if (w_sel_op == ALU_MUL) begin
                            r_alu_a    <= '0;
                            r_alu_b    <= w_sel_b[0] ? w_sel_a : '0;
                            r_alu_ctrl <= ALU_ADD;
                            r_mcand    <= w_sel_a << 1;
                            r_mplier   <= w_sel_b >> 1;
                            r_mcnt     <= '0;
                            r_state    <= MUL;
                        end
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EXEC: begin
                    r_rsp_result       <= bus.alu_result;
                    r_rsp_zero         <= bus.alu_zero;
                    r_rsp_id           <= r_id;
                    r_rsp_valid[r_id]  <= 1'b1;
                    r_state            <= RESP;
                end
`ifdef ALU_SCHED_MUL_EN
                MUL: begin
                    r_alu_a  <= bus.alu_result;
                    r_alu_b  <= r_mplier[0] ? r_mcand : '0;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_mcnt   <= r_mcnt + CNT_W'(1);
                    if (r_mcnt == CNT_W'(WIDTH - 1)) begin
                        r_rsp_result      <= bus.alu_result;
                        r_rsp_zero        <= (bus.alu_result == '0);
                        r_rsp_id          <= r_id;
                        r_rsp_valid[r_id] <= 1'b1;
                        r_state           <= RESP;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = rst_n ? w_gnt : '0;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_control = r_alu_ctrl;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_zero    = r_rsp_zero;

endmodule

// File: tb/tb_alu_sched.sv
// Randomized self-checking bench for alu_sched against a transaction-level model
// (round-robin pointer, busy-until-response window, queue of due responses).
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int WIDTH  = 8;
    localparam int NREQ   = 2;
    localparam int PERIOD = 10;
`ifdef ALU_SCHED_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #(PERIOD/2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shared ALU environment model.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
        case (op)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] expect_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input logic [2:0] op);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        if (MUL_ON && op == ALU_MUL) return prod[WIDTH-1:0];
        return alu_fn(a, b, op);
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_control);
    assign bus.alu_zero   = (bus.alu_result == '0);

    typedef struct {
        int               due;
        int               id;
        logic [WIDTH-1:0] res;
        logic             z;
    } rsp_t;

    rsp_t             pend[$];
    int               cyc    = 0;
    int               m_ptr  = 0;
    int               m_free = 0;
    int               m_exec = -1;
    logic [WIDTH-1:0] m_a    = '0;
    logic [WIDTH-1:0] m_b    = '0;
    logic [2:0]       m_op   = '0;
    int               m_rid  = 0;
    logic [WIDTH-1:0] m_res  = '0;
    logic             m_z    = 1'b0;
    logic [NREQ-1:0]  last_xfer = '0;

    // Compare process: one check set per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        logic [NREQ-1:0]  exp_ready;
        logic [NREQ-1:0]  exp_rsp;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        int               w;
        int               lat;
        rsp_t             p;
        if (!rst_n) begin
            check("rst_req_ready",   32'(bus.req_ready), 0);
            check("rst_rsp_valid",   32'(bus.rsp_valid), 0);
            check("rst_rsp_id",      32'(bus.rsp_id), 0);
            check("rst_rsp_result",  32'(bus.rsp_result), 0);
            check("rst_rsp_zero",    32'(bus.rsp_zero), 0);
            check("rst_alu_a",       32'(bus.alu_a), 0);
            check("rst_alu_b",       32'(bus.alu_b), 0);
            check("rst_alu_control", 32'(bus.alu_control), 0);
            pend.delete();
            m_ptr = 0; m_free = cyc; m_exec = -1;
            m_rid = 0; m_res = '0; m_z = 1'b0;
            last_xfer = '0;
        end else begin
            exp_ready = '0;
            w = -1;
            if (cyc >= m_free) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && bus.req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
            end
            if (w >= 0) exp_ready[w] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));

            exp_rsp = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                p = pend.pop_front();
                exp_rsp[p.id] = 1'b1;
                m_rid = p.id; m_res = p.res; m_z = p.z;
            end
            check("rsp_valid",  32'(bus.rsp_valid), 32'(exp_rsp));
            check("rsp_id",     32'(bus.rsp_id), 32'(m_rid));
            check("rsp_result", 32'(bus.rsp_result), 32'(m_res));
            check("rsp_zero",   32'(bus.rsp_zero), 32'(m_z));

            if (m_exec == cyc) begin
                check("exec_alu_a",       32'(bus.alu_a), 32'(m_a));
                check("exec_alu_b",       32'(bus.alu_b), 32'(m_b));
                check("exec_alu_control", 32'(bus.alu_control), 32'(m_op));
            end

            if (w >= 0) begin
                a  = bus.req_a[w*WIDTH +: WIDTH];
                b  = bus.req_b[w*WIDTH +: WIDTH];
                op = bus.req_op[w*3 +: 3];
                lat = (MUL_ON && op == ALU_MUL) ? WIDTH + 1 : 2;
                p.due = cyc + lat;
                p.id  = w;
                p.res = expect_fn(a, b, op);
                p.z   = (p.res == '0);
                pend.push_back(p);
                m_free = cyc + lat;
                m_ptr  = (w + 1) % NREQ;
                if (lat == 2) begin
                    m_exec = cyc + 1; m_a = a; m_b = b; m_op = op;
                end
            end
            last_xfer = exp_ready;
        end
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] op);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_op[i*3 +: 3]        = op;
    endtask

    task automatic new_op(input int i);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = WIDTH'($urandom);
        b = ($urandom_range(3) == 0) ? a : WIDTH'($urandom);
        set_req(i, a, b, 3'($urandom_range(7)));
    endtask

    // Single request from one requester; returns latency from transfer to response and the response.
    task automatic run_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] op, output int lat, output logic [WIDTH-1:0] res,
                          output logic z, output int rid, output logic [NREQ-1:0] rv);
        time t0;
        bit  got;
        lat = -1; res = '0; z = 1'b0; rid = -1; rv = '0; t0 = 0;
        @(posedge clk); #1;
        bus.req_valid = '0;
        set_req(id, a, b, op);
        bus.req_valid[id] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin got = 1; t0 = $time; end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("run_grant_seen", 32'(got), 1);
        if (got) begin
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                if (bus.rsp_valid != '0) begin
                    got = 1;
                    lat = int'(($time - t0) / PERIOD);
                    res = bus.rsp_result; z = bus.rsp_zero; rid = int'(bus.rsp_id); rv = bus.rsp_valid;
                end
            end
            check("run_rsp_seen", 32'(got), 1);
        end
    endtask

    initial begin
        #(PERIOD * 50000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int               lat;
        int               rid;
        int               pulses;
        bit               got;
        logic [WIDTH-1:0] res;
        logic             z;
        logic [NREQ-1:0]  rv;
        int               seq[$];

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op(0, 8'h05, 8'h03, ALU_ADD, lat, res, z, rid, rv);
        check("add_latency",   32'(lat), 2);
        check("add_rsp_valid", 32'(rv), 32'h1);
        check("add_result",    32'(res), 32'h08);
        check("add_zero",      32'(z), 0);
        idle(3);

        run_op(1, 8'h07, 8'h07, ALU_SUB, lat, res, z, rid, rv);
        check("sub_rsp_valid", 32'(rv), 32'h2);
        check("sub_result",    32'(res), 32'h00);
        check("sub_zero",      32'(z), 1);
        check("sub_id",        32'(rid), 1);
        idle(3);

        // Both requesters valid: grants must alternate starting at requester 0.
        @(posedge clk); #1;
        set_req(0, 8'h21, 8'h13, ALU_ADD);
        set_req(1, 8'h40, 8'h0F, ALU_OR);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 60 && seq.size() < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) seq.push_back(i);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        check("alt_grant_count", 32'(seq.size()), 6);
        foreach (seq[k]) check($sformatf("alt_grant_%0d", k), 32'(seq[k]), 32'(k % 2));
        idle(4);

        // Continuous SLT stream from requester 0: one response every two cycles.
        @(posedge clk); #1;
        set_req(0, 8'h02, 8'h05, ALU_SLT);
        bus.req_valid = 2'b01;
        got = 0; res = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != '0) begin got = 1; res = bus.rsp_result; end
        end
        check("slt_rsp_seen", 32'(got), 1);
        check("slt_result",   32'(res), 32'h01);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid[0]) pulses++;
        end
        check("slt_back_to_back_pulses", 32'(pulses), 10);
        @(posedge clk); #1;
        bus.req_valid = '0;
        idle(4);

`ifdef ALU_SCHED_MUL_EN
        run_op(0, 8'h0C, 8'h0B, ALU_MUL, lat, res, z, rid, rv);
        check("mul_latency", 32'(lat), 9);
        check("mul_result",  32'(res), 32'h84);
        check("mul_zero",    32'(z), 0);
        idle(3);
        run_op(1, 8'h10, 8'h10, ALU_MUL, lat, res, z, rid, rv);
        check("mul_wrap_result", 32'(res), 32'h00);
        check("mul_wrap_zero",   32'(z), 1);
        idle(3);
`endif

        // Reset during EXEC: outputs clear at once, no response, pointer back to 0.
        @(posedge clk); #1;
        set_req(0, 8'h11, 8'h22, ALU_ADD);
        bus.req_valid = 2'b01;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready[0]) got = 1;
        end
        check("rst_pre_grant", 32'(got), 1);
        @(posedge clk); #2;
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rst_now_alu_a",       32'(bus.alu_a), 0);
        check("rst_now_alu_b",       32'(bus.alu_b), 0);
        check("rst_now_alu_control", 32'(bus.alu_control), 0);
        check("rst_now_rsp_valid",   32'(bus.rsp_valid), 0);
        check("rst_now_rsp_result",  32'(bus.rsp_result), 0);
        repeat (2) @(posedge clk);
        #2;
        set_req(0, 8'h3C, 8'h0F, ALU_AND);
        set_req(1, 8'h01, 8'h02, ALU_OR);
        bus.req_valid = 2'b11;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        idle(4);

        // Randomized traffic, including withdrawals before grant.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && last_xfer[i]) begin
                    if ($urandom_range(3) == 0) bus.req_valid[i] = 1'b0;
                    else new_op(i);
                end else if (bus.req_valid[i]) begin
                    if ($urandom_range(15) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    new_op(i);
                    bus.req_valid[i] = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
